// File: rtl/uart_rx.sv
// uart_rx: receives 8-bit UART frames (1 start, 8 data LSB first, optional
// parity, 1 stop, one bit per clk) and packs four of them into a 32-bit word,
// least-significant byte first.
module uart_rx #(
    parameter logic PARITY_ON  = 1'b1,  // 1: a parity bit follows the data bits
    parameter logic PARITY_BIT = 1'b0   // 0: even parity, 1: odd parity
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    output logic [31:0] data_out,
    output logic        rx_done,
    output logic        parity_err,
    output logic        frame_err
);

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PARITY,
        STOP,
        BREAK
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_reg;
    logic [31:0] word_reg;
    logic [1:0]  byte_idx;
    logic        perr_acc;
    logic        expected_par;

    // Parity the sender should have sent for the byte now in the shift register.
    assign expected_par = (^shift_reg) ^ PARITY_BIT;

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; a low line after a framing error is not a start bit
    // until it has gone high again.
    // NOTE: next_state gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!rx) next_state = DATA;
            DATA:    if (bit_cnt == 3'd7) next_state = (PARITY_ON != 1'b0) ? PARITY : STOP;
            PARITY:  next_state = STOP;
            STOP:    next_state = rx ? IDLE : BREAK;
            BREAK:   if (rx) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath: bit shifting, parity accumulation, byte packing and the
    // one-cycle result flags.
    // NOTE: word_reg is an ordinary register bank, not a RAM, so it is reset
    // along with everything else and a partial word never leaks past reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt    <= 3'd0;
            shift_reg  <= 8'd0;
            word_reg   <= 32'd0;
            byte_idx   <= 2'd0;
            perr_acc   <= 1'b0;
            data_out   <= 32'd0;
            rx_done    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_done    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx) bit_cnt <= 3'd0;
                end
                DATA: begin
                    shift_reg <= {rx, shift_reg[7:1]};
                    bit_cnt   <= bit_cnt + 3'd1;
                end
                PARITY: begin
                    perr_acc <= perr_acc | (rx != expected_par);
                end
                STOP: begin
                    if (rx) begin
                        word_reg[{byte_idx, 3'b000} +: 8] <= shift_reg;
                        byte_idx <= byte_idx + 2'd1;  // wraps 3 -> 0 on delivery
                        if (byte_idx == 2'd3) begin
                            data_out   <= {shift_reg, word_reg[23:0]};
                            rx_done    <= 1'b1;
                            parity_err <= perr_acc;
                            perr_acc   <= 1'b0;
                        end
                    end else begin
                        // Bad stop bit: drop the partial word, keep data_out.
                        frame_err <= 1'b1;
                        byte_idx  <= 2'd0;
                        perr_acc  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed tests for uart_rx, with parity (even) and without.
module tb_uart_rx;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx    = 1'b1;
    logic        rx_np = 1'b1;
    logic [31:0] data_out, np_data_out;
    logic        rx_done, parity_err, frame_err;
    logic        np_rx_done, np_parity_err, np_frame_err;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int          cyc      = 0;

    int          done_cyc_q[$];
    logic [31:0] done_data_q[$];
    logic        done_perr_q[$];
    int          ferr_cyc_q[$];
    int          both_cnt = 0;
    int          np_done_cyc_q[$];
    logic [31:0] np_done_data_q[$];
    logic        np_done_perr_q[$];
    int          np_ferr_cnt = 0;

    uart_rx #(.PARITY_ON(1'b1), .PARITY_BIT(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .data_out(data_out),
        .rx_done(rx_done), .parity_err(parity_err), .frame_err(frame_err)
    );

    uart_rx #(.PARITY_ON(1'b0), .PARITY_BIT(1'b0)) dut_np (
        .clk(clk), .rst_n(rst_n), .rx(rx_np), .data_out(np_data_out),
        .rx_done(np_rx_done), .parity_err(np_parity_err), .frame_err(np_frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every strobe on the falling edge, away from the sampling edge.
    always @(negedge clk) begin
        if (rx_done === 1'b1) begin
            done_cyc_q.push_back(cyc);
            done_data_q.push_back(data_out);
            done_perr_q.push_back(parity_err);
        end
        if (frame_err === 1'b1) ferr_cyc_q.push_back(cyc);
        if (rx_done === 1'b1 && frame_err === 1'b1) both_cnt++;
        if (np_rx_done === 1'b1) begin
            np_done_cyc_q.push_back(cyc);
            np_done_data_q.push_back(np_data_out);
            np_done_perr_q.push_back(np_parity_err);
        end
        if (np_frame_err === 1'b1) np_ferr_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_bit(input logic v);
        rx = v;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit_np(input logic v);
        rx_np = v;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic flip_par, input logic bad_stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((^b) ^ flip_par);
        send_bit(~bad_stop);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap, input int flip_idx);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[k*8 +: 8], (k == flip_idx), 1'b0);
            if (k < 3) repeat (gap) send_bit(1'b1);
        end
        rx = 1'b1;
    endtask

    task automatic send_word_np(input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            send_bit_np(1'b0);
            for (int i = 0; i < 8; i++) send_bit_np(w[k*8 + i]);
            send_bit_np(1'b1);
        end
        rx_np = 1'b1;
    endtask

    task automatic wait_done(input int n);
        for (int i = 0; i < 20 && done_cyc_q.size() < n; i++) @(negedge clk);
        n_checks++;
        if (done_cyc_q.size() !== n) begin
            n_fail++;
            $display("FAIL done_count: got %0d expected %0d", done_cyc_q.size(), n);
        end
    endtask

    task automatic wait_done_np(input int n);
        for (int i = 0; i < 20 && np_done_cyc_q.size() < n; i++) @(negedge clk);
        n_checks++;
        if (np_done_cyc_q.size() !== n) begin
            n_fail++;
            $display("FAIL np_done_count: got %0d expected %0d", np_done_cyc_q.size(), n);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        n_checks++; if (data_out !== 32'd0) begin n_fail++; $display("FAIL reset_data_out: got %h expected 00000000", data_out); end
        n_checks++; if (rx_done !== 1'b0) begin n_fail++; $display("FAIL reset_rx_done: got %b expected 0", rx_done); end
        n_checks++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_parity_err: got %b expected 0", parity_err); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        n_checks++; if (np_data_out !== 32'd0) begin n_fail++; $display("FAIL reset_np_data_out: got %h expected 00000000", np_data_out); end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_word;
        int n, t0;
        n  = done_cyc_q.size();
        t0 = cyc;
        send_word(32'hDEADBEEF, 1, -1);
        wait_done(n + 1);
        if (done_cyc_q.size() > n) begin
            n_checks++; if (done_data_q[n] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_data: got %h expected deadbeef", done_data_q[n]); end
            n_checks++; if (done_perr_q[n] !== 1'b0) begin n_fail++; $display("FAIL single_perr: got %b expected 0", done_perr_q[n]); end
            n_checks++; if (done_cyc_q[n] !== t0 + 47) begin n_fail++; $display("FAIL single_latency: got %0d expected %0d", done_cyc_q[n] - t0, 47); end
        end
        n_checks++; if (ferr_cyc_q.size() !== 0) begin n_fail++; $display("FAIL single_no_frame_err: got %0d expected 0", ferr_cyc_q.size()); end
    endtask

    task automatic test_parity_err;
        int n;
        n = done_cyc_q.size();
        send_word(32'h12345678, 1, 2);
        wait_done(n + 1);
        if (done_cyc_q.size() > n) begin
            n_checks++; if (done_data_q[n] !== 32'h12345678) begin n_fail++; $display("FAIL perr_data: got %h expected 12345678", done_data_q[n]); end
            n_checks++; if (done_perr_q[n] !== 1'b1) begin n_fail++; $display("FAIL perr_flag: got %b expected 1", done_perr_q[n]); end
        end
        send_bit(1'b1);
        send_word(32'h0000FFFF, 1, -1);
        wait_done(n + 2);
        if (done_cyc_q.size() > n + 1) begin
            n_checks++; if (done_data_q[n+1] !== 32'h0000FFFF) begin n_fail++; $display("FAIL perr_clean_data: got %h expected 0000ffff", done_data_q[n+1]); end
            n_checks++; if (done_perr_q[n+1] !== 1'b0) begin n_fail++; $display("FAIL perr_clean_flag: got %b expected 0", done_perr_q[n+1]); end
        end
    endtask

    task automatic test_frame_err;
        int n, nf, t, t0;
        n  = done_cyc_q.size();
        nf = ferr_cyc_q.size();
        send_byte(8'h11, 1'b0, 1'b0);
        send_bit(1'b1);
        send_byte(8'h22, 1'b0, 1'b0);
        send_bit(1'b1);
        t = cyc;
        send_byte(8'h33, 1'b0, 1'b1);
        repeat (5) send_bit(1'b0);
        n_checks++; if (ferr_cyc_q.size() !== nf + 1) begin n_fail++; $display("FAIL ferr_count: got %0d expected %0d", ferr_cyc_q.size(), nf + 1); end
        if (ferr_cyc_q.size() > nf) begin
            n_checks++; if (ferr_cyc_q[nf] !== t + 11) begin n_fail++; $display("FAIL ferr_timing: got %0d expected %0d", ferr_cyc_q[nf] - t, 11); end
        end
        n_checks++; if (done_cyc_q.size() !== n) begin n_fail++; $display("FAIL ferr_no_done: got %0d expected %0d", done_cyc_q.size(), n); end
        n_checks++; if (data_out !== 32'h0000FFFF) begin n_fail++; $display("FAIL ferr_data_held: got %h expected 0000ffff", data_out); end
        send_bit(1'b1);
        t0 = cyc;
        send_word(32'hA5A5A5A5, 0, -1);
        wait_done(n + 1);
        if (done_cyc_q.size() > n) begin
            n_checks++; if (done_data_q[n] !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL ferr_recover_data: got %h expected a5a5a5a5", done_data_q[n]); end
            n_checks++; if (done_cyc_q[n] !== t0 + 44) begin n_fail++; $display("FAIL ferr_recover_latency: got %0d expected %0d", done_cyc_q[n] - t0, 44); end
        end
    endtask

    task automatic test_back_to_back;
        int n, t0;
        n  = done_cyc_q.size();
        t0 = cyc;
        send_word(32'h01020304, 0, -1);
        send_word(32'hCAFEF00D, 0, -1);
        wait_done(n + 2);
        if (done_cyc_q.size() > n + 1) begin
            n_checks++; if (done_cyc_q[n] !== t0 + 44) begin n_fail++; $display("FAIL b2b_latency0: got %0d expected %0d", done_cyc_q[n] - t0, 44); end
            n_checks++; if (done_cyc_q[n+1] !== t0 + 88) begin n_fail++; $display("FAIL b2b_latency1: got %0d expected %0d", done_cyc_q[n+1] - t0, 88); end
            n_checks++; if (done_data_q[n] !== 32'h01020304) begin n_fail++; $display("FAIL b2b_data0: got %h expected 01020304", done_data_q[n]); end
            n_checks++; if (done_data_q[n+1] !== 32'hCAFEF00D) begin n_fail++; $display("FAIL b2b_data1: got %h expected cafef00d", done_data_q[n+1]); end
            n_checks++; if (done_perr_q[n+1] !== 1'b0) begin n_fail++; $display("FAIL b2b_perr: got %b expected 0", done_perr_q[n+1]); end
        end
    endtask

    task automatic test_reset_mid_word;
        int n, t0;
        n = done_cyc_q.size();
        send_byte(8'h3C, 1'b0, 1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (data_out !== 32'd0) begin n_fail++; $display("FAIL midrst_data_out: got %h expected 00000000", data_out); end
        n_checks++; if (rx_done !== 1'b0) begin n_fail++; $display("FAIL midrst_rx_done: got %b expected 0", rx_done); end
        n_checks++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL midrst_parity_err: got %b expected 0", parity_err); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL midrst_frame_err: got %b expected 0", frame_err); end
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        send_word(32'h55AA55AA, 0, -1);
        wait_done(n + 1);
        if (done_cyc_q.size() > n) begin
            n_checks++; if (done_data_q[n] !== 32'h55AA55AA) begin n_fail++; $display("FAIL midrst_new_data: got %h expected 55aa55aa", done_data_q[n]); end
            n_checks++; if (done_cyc_q[n] !== t0 + 44) begin n_fail++; $display("FAIL midrst_latency: got %0d expected %0d", done_cyc_q[n] - t0, 44); end
        end
    endtask

    task automatic test_no_parity;
        int n, t0;
        n  = np_done_cyc_q.size();
        t0 = cyc;
        send_word_np(32'h89ABCDEF);
        wait_done_np(n + 1);
        if (np_done_cyc_q.size() > n) begin
            n_checks++; if (np_done_data_q[n] !== 32'h89ABCDEF) begin n_fail++; $display("FAIL np_data: got %h expected 89abcdef", np_done_data_q[n]); end
            n_checks++; if (np_done_cyc_q[n] !== t0 + 40) begin n_fail++; $display("FAIL np_latency: got %0d expected %0d", np_done_cyc_q[n] - t0, 40); end
            n_checks++; if (np_done_perr_q[n] !== 1'b0) begin n_fail++; $display("FAIL np_perr: got %b expected 0", np_done_perr_q[n]); end
        end
        n_checks++; if (np_ferr_cnt !== 0) begin n_fail++; $display("FAIL np_frame_err: got %0d expected 0", np_ferr_cnt); end
    endtask

    task automatic test_totals;
        repeat (3) @(negedge clk);
        n_checks++; if (both_cnt !== 0) begin n_fail++; $display("FAIL done_and_ferr_together: got %0d expected 0", both_cnt); end
        n_checks++; if (done_cyc_q.size() !== 7) begin n_fail++; $display("FAIL total_words: got %0d expected 7", done_cyc_q.size()); end
        n_checks++; if (ferr_cyc_q.size() !== 1) begin n_fail++; $display("FAIL total_frame_errs: got %0d expected 1", ferr_cyc_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_parity_err();
        test_frame_err();
        test_back_to_back();
        test_reset_mid_word();
        test_no_parity();
        test_totals();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
